fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream consumer of the sync FIFO. Pops one word at a time through the FIFO read port and serialises it onto a UART TX line as start, data (LSB first), [parity] and stop bits. It accounts for the FIFO's one-cycle registered read latency: dout is valid the cycle after a qualified re.

Parameters:
DWIDTH, 8, data word width; must match the FIFO data width
CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_en  input  1  level enable; new frames start only while high
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DWIDTH  FIFO registered read data
fifo_re  output  1  FIFO read strobe, one-cycle pulse
txd  output  1  serial line, idles high
busy  output  1  high from FETCH through the end of STOP
frame_done  output  1  one-cycle pulse in the last cycle of STOP

Behaviour:
- Reset (async assert, sync release): state=IDLE; txd=1, fifo_re=0, busy=0, frame_done=0; bit counter, baud counter and shift register = 0.
- Reset mid-frame: txd returns high immediately and the in-flight word is dropped. The FIFO is not rewound.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY (only when the macro is set), STOP.
- IDLE: if tx_en & ~fifo_empty, go to FETCH; else stay. txd=1.
- FETCH (1 cycle): fifo_re=1, busy=1. Go to LOAD.
- LOAD (1 cycle): shift register <= fifo_dout; baud counter cleared. Go to START.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA: txd=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After DWIDTH bits go to PARITY or STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Next state is IDLE.
- Start of next frame: IDLE re-evaluates the following cycle. Back-to-back frames therefore have exactly 1 idle-high cycle plus FETCH and LOAD between stop bit and next start bit (3 extra txd-high cycles).
- Timing: fifo_re is the only FIFO interaction. It is never asserted while fifo_empty=1 in the same cycle, and never more than once per frame.
- tx_en: sampled only in IDLE. Deasserting it mid-frame lets the current frame complete.
- fifo_empty rising during LOAD is irrelevant: the word was already popped.
- Counters:
  - baud counter width $clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT-1.
  - bit counter width $clog2(DWIDTH+1).
- txd and fifo_re are registered outputs (no combinational path from inputs).

Optional Feature:
UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA. txd = XOR of the frame's data bits (even parity) for CLKS_PER_BIT cycles, then STOP. The parity bit is computed at LOAD from fifo_dout.
- Undefined: DATA goes straight to STOP and no parity logic is synthesised.
- Frame length: 1+DWIDTH+1 bits without the macro, 1+DWIDTH+1+1 bits with it.

Test Plan:
- 0xA5, CLKS_PER_BIT=4, no parity, tx_en=1:
  - fifo_re pulses once.
  - txd = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles).
  - frame_done pulses on cycle 40 of the frame.
- fifo_empty=1, tx_en=1 for 100 cycles -> fifo_re never asserts, txd stays 1, busy=0.
- FIFO preloaded with 0x00, 0xFF:
  - two frames, first data all 0, second data all 1.
  - exactly 3 high cycles between the first stop bit's end and the second start bit.
  - fifo_re pulses exactly twice.
- tx_en dropped during DATA of 0x3C -> frame completes normally; no further fifo_re while tx_en=0.
- rst asserted during bit 3 of DATA -> txd=1, busy=0 before the next clk edge; after release, the next frame starts only when tx_en & ~fifo_empty.
- UART_TX_PARITY_EN set, 0xA5 -> parity bit 0, stop follows (44 cycles). 0x07 -> parity bit 1.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
// FIFO read-port bundle between a sync FIFO and the UART transmitter.
// master = transmitter (issues reads), slave = FIFO (supplies data).
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int DWIDTH = 8
);
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_dout;
  logic              fifo_re;

  modport master (output fifo_re, input fifo_empty, input fifo_dout);
  modport slave  (input fifo_re, output fifo_empty, output fifo_dout);
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops words from a sync FIFO (one-cycle registered read latency) and
// serialises them as start, data (LSB first), optional even parity, stop.
// Optional feature macro: UART_TX_PARITY_EN (adds a parity bit per frame).
// CLKS_PER_BIT must be >= 2.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DWIDTH       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           tx_en,
  fifo_uart_tx_if.master      fifo,
  output logic                txd,
  output logic                busy,
  output logic                frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DWIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              fifo_re_q, fifo_re_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic baud_last;
  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // State, counters and registered outputs; reset parks the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      fifo_re_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      fifo_re_q <= fifo_re_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state, baud/bit counting and data shifting.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        // tx_en only matters here, so dropping it mid-frame is harmless.
        if (tx_en && !fifo.fifo_empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // fifo_dout is valid now, one cycle after the read strobe.
        shift_d  = fifo.fifo_dout;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo.fifo_dout;
`endif
        baud_d   = '0;
        bit_d    = '0;
        state_d  = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DWIDTH - 1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: txd/fifo_re are precomputed from the next state so the flops
  // present the value belonging to the state they enter.
  always_comb begin
    fifo_re_d = (state_d == S_FETCH);
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_STOP) && baud_last;
  end

  assign txd          = txd_q;
  assign fifo.fifo_re = fifo_re_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with a small FIFO model (registered read).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic txd, busy, frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_uart_tx_if #(.DWIDTH(8)) fif ();

  fifo_uart_tx #(.DWIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo       (fif.master),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, one cycle after re
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int re_cnt = 0;
  int re_viol = 0;
  assign fif.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fif.fifo_re) begin
      fif.fifo_dout <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
      re_cnt++;
      if (fif.fifo_empty) re_viol++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 64] = d;
    wr_ptr++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // waits (bounded) for a start bit; gap = high cycles seen before it
  task automatic wait_start(output int gap);
    gap = 0;
    while (gap < TMO) begin
      @(negedge clk);
      if (txd === 1'b0) break;
      gap++;
    end
  endtask

  task automatic check_frame(input logic [7:0] d, input string tag,
                             input int drop_at, output int gap);
    int g;
    wait_start(g);
    gap = g;
    chk({tag, " start_seen"}, 32'(g < TMO), 32'd1);
    if (g >= TMO) return;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("%s txd c%0d", tag, c), 32'(txd), 32'(exp_bit(d, c / CPB)));
      chk($sformatf("%s frame_done c%0d", tag, c), 32'(frame_done), 32'(c == FRAME - 1));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      if (c == drop_at) begin
        tx_en = 1'b0;
        push(8'h11);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, i), {29'd0, txd, busy, fif.fifo_re}, 32'b100);
    end
  endtask

  initial begin
    int g, r0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst txd", 32'(txd), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst fifo_re", 32'(fif.fifo_re), 32'd0);
    chk("rst frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // empty FIFO with tx_en high: nothing happens
    tx_en = 1'b1;
    idle_cycles(100, "empty_idle");
    chk("empty re_cnt", 32'(re_cnt), 32'd0);

    // single 0xA5 frame
    r0 = re_cnt;
    push(8'hA5);
    check_frame(8'hA5, "a5", -1, g);
    chk("a5 re pulses", 32'(re_cnt - r0), 32'd1);

    // back-to-back 0x00, 0xFF
    r0 = re_cnt;
    push(8'h00);
    push(8'hFF);
    check_frame(8'h00, "f00", -1, g);
    check_frame(8'hFF, "fff", -1, g);
    chk("b2b gap", 32'(g), 32'd3);
    chk("b2b re pulses", 32'(re_cnt - r0), 32'd2);

    // tx_en dropped during DATA of 0x3C; 0x11 pushed meanwhile must wait
    r0 = re_cnt;
    push(8'h3C);
    check_frame(8'h3C, "f3c", 20, g);
    idle_cycles(30, "txen_low");
    chk("txen_low re pulses", 32'(re_cnt - r0), 32'd1);
    tx_en = 1'b1;
    check_frame(8'h11, "f11", -1, g);

    // 0x07: odd number of ones (parity bit 1 when enabled)
    push(8'h07);
    check_frame(8'h07, "f07", -1, g);

    // reset during DATA bit 3 of 0x81
    push(8'h81);
    wait_start(g);
    chk("rstmid start_seen", 32'(g < TMO), 32'd1);
    repeat (17) @(negedge clk);
    chk("rstmid txd bit3", 32'(txd), 32'd0);
    chk("rstmid busy pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid txd", 32'(txd), 32'd1);
    chk("rstmid busy", 32'(busy), 32'd0);
    chk("rstmid fifo_re", 32'(fif.fifo_re), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r0 = re_cnt;
    idle_cycles(20, "post_rst_empty");
    tx_en = 1'b0;
    push(8'h42);
    idle_cycles(10, "post_rst_txen0");
    chk("post_rst re pulses", 32'(re_cnt - r0), 32'd0);
    tx_en = 1'b1;
    check_frame(8'h42, "f42", -1, g);

    chk("re while empty", 32'(re_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
